alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
Parametrised successor to the two-way ALU operand select. Selects ALU operands from register file, PC, immediate or constant sources, and resolves RAW hazards by forwarding from NUM_FWD later pipeline stages. Registers the result into the ID/EX boundary behind a valid/ready handshake, with load-use stall, flush and a saturating stall counter. Sits between decode/register-read and the ALU.

Parameters:
XLEN, 32, operand/data width
NUM_FWD, 2, number of forwarding sources; index 0 = youngest (EX/MEM), highest priority
RA_W, 5, register address width
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  kill held operands (branch/trap)
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage accepts this cycle
d1_sel  in  2  00 rs1, 01 pc, 10 zero, 11 reserved (treated as zero)
d2_sel  in  2  00 rs2, 01 immediate, 10 constant 4, 11 reserved (treated as zero)
rs1_addr  in  RA_W  source 1 register index
rs2_addr  in  RA_W  source 2 register index
rs1_data  in  XLEN  register file read 1
rs2_data  in  XLEN  register file read 2
immediate  in  XLEN  decoded immediate
pc  in  XLEN  instruction PC
fwd_valid  in  NUM_FWD  source i writes a register
fwd_rd  in  NUM_FWD*RA_W  destination index per source, packed, i at [i*RA_W +: RA_W]
fwd_data  in  NUM_FWD*XLEN  result per source, packed
fwd_data_ok  in  NUM_FWD  source i data available (0 = load in flight)
out_valid  out  1  registered operands valid
out_ready  in  1  ALU/EX accepts
alu_data_1  out  XLEN  registered operand 1
alu_data_2  out  XLEN  registered operand 2
store_data  out  XLEN  registered forwarded rs2 value, independent of d2_sel
stall_count  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (rst_n low, async): out_valid=0, alu_data_1/2=0, store_data=0, stall_count=0.
- Forward resolution, combinational, per source s in {rs1, rs2}: match_i = fwd_valid[i] && fwd_rd_i==addr && addr!=0. The lowest matching i wins. With no match, the value is the register file data.
- x0: never forwarded; rs*_data passes through unchanged.
- hazard = in_valid && (a winning match for rs1 or rs2 has fwd_data_ok=0). Checked for rs1 only when d1_sel=00. Checked for rs2 when d2_sel=00, or always when rs2_addr!=0, so stores get valid data. A reserved d*_sel code never raises a hazard for that operand.
- in_ready = !hazard && !flush && (!out_valid || out_ready).
- Load, 1-cycle latency: when in_valid && in_ready, the next edge captures mux outputs into alu_data_1/2/store_data and sets out_valid=1.
- Drain: out_valid && out_ready with no load gives out_valid=0 next edge. Data registers hold their values, with no toggle needed.
- Hold: out_valid && !out_ready keeps all outputs stable. No overwrite.
- Simultaneous drain and load in the same cycle: out_valid stays 1 with the new data, giving full throughput.
- flush has top priority: next edge out_valid=0. Input is not accepted that cycle. Data registers are don't-care.
- stall_count increments by 1 each cycle hazard=1, and saturates at all-ones. It is cleared only by reset.
- Reset asserted mid-transfer: outputs return to reset values immediately. The handshake resumes from empty.
- Width rules: all data XLEN. The constant 4 is zero-extended to XLEN. There is no arithmetic besides the counter.

Decomposition:
- Shared package: operand-select encodings (OP1_RS1/PC/ZERO, OP2_RS2/IMM/FOUR) and the REG_ZERO constant.
- One sub-module, fwd_resolve: parametrised priority match for one source over NUM_FWD entries. It returns the resolved value and a not_ready flag, and is instantiated twice (rs1, rs2).

Test Plan:
- No hazard, d1_sel=00, d2_sel=01, rs1_data=0x10, imm=0x20, out_ready=1 -> next cycle out_valid=1, alu_data_1=0x10, alu_data_2=0x20; back-to-back inputs accepted every cycle.
- rs1_addr=5, fwd_valid=2'b11, fwd_rd both 5, fwd_data[0]=0xAAAA, [1]=0xBBBB, ok=11 -> alu_data_1=0xAAAA (youngest wins); with rs1_addr=0 -> rs1_data used.
- Load-use: rs2_addr=7 matches fwd 0 with fwd_data_ok[0]=0 for 3 cycles -> in_ready=0 for 3 cycles, stall_count=3; on ok=1, forwarded value 0x1234 is captured.
- Backpressure: out_ready=0 for 4 cycles after load -> outputs stable and in_ready=0; out_ready=1 with in_valid=1 -> new data replaces old in one edge.
- flush while out_valid=1 and in_valid=1 -> next cycle out_valid=0, input not accepted; d2_sel=10 after flush -> alu_data_2=4, store_data = forwarded rs2.
- Counter saturation, CNT_W=4: 20 hazard cycles -> stall_count=15; async rst_n low mid-stall -> stall_count=0 and out_valid=0 immediately.

Source files
------------

// File: rtl/alu_operand_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_operand_stage_pkg
//
// Purpose : Shared encodings for the ALU operand stage. It holds the
//           operand-select codes for both ALU inputs, the architectural zero
//           register index and the constant used for PC+4 style operations.
//
// Contents:
//   op1_sel_e  - operand 1 source select (rs1 / pc / zero / reserved)
//   op2_sel_e  - operand 2 source select (rs2 / imm / four / reserved)
//   REG_ZERO   - index of the hard-wired zero register (never forwarded)
//   CONST_FOUR - value driven on operand 2 for OP2_FOUR
// -----------------------------------------------------------------------------
package alu_operand_stage_pkg;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'b00,
        OP1_PC   = 2'b01,
        OP1_ZERO = 2'b10,
        OP1_RSVD = 2'b11
    } op1_sel_e;

    typedef enum logic [1:0] {
        OP2_RS2  = 2'b00,
        OP2_IMM  = 2'b01,
        OP2_FOUR = 2'b10,
        OP2_RSVD = 2'b11
    } op2_sel_e;

    localparam int unsigned REG_ZERO   = 0;
    localparam int unsigned CONST_FOUR = 4;

endpackage : alu_operand_stage_pkg

// File: rtl/alu_operand_stage_fwd_resolve.sv
// -----------------------------------------------------------------------------
// alu_operand_stage_fwd_resolve
//
// Purpose : Resolves one source register against NUM_FWD forwarding sources.
//           Source 0 is the youngest in-flight result and has the highest
//           priority. The zero register is never forwarded. When the winning
//           source has no data yet (a load still in flight), o_not_ready is
//           raised so the caller can stall.
//
// Ports:
//   i_addr        - source register index
//   i_rf_data     - register file read value, used when nothing matches
//   i_fwd_valid   - per-source "writes a register" flag
//   i_fwd_rd      - per-source destination index, packed, i at [i*RA_W +: RA_W]
//   i_fwd_data    - per-source result, packed, i at [i*XLEN +: XLEN]
//   i_fwd_data_ok - per-source "result available" flag
//   o_value       - resolved operand value
//   o_not_ready   - winning source exists but its data is not available
// -----------------------------------------------------------------------------
module alu_operand_stage_fwd_resolve
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned RA_W    = 5
) (
    input  logic [RA_W-1:0]         i_addr,
    input  logic [XLEN-1:0]         i_rf_data,
    input  logic [NUM_FWD-1:0]      i_fwd_valid,
    input  logic [NUM_FWD*RA_W-1:0] i_fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0] i_fwd_data,
    input  logic [NUM_FWD-1:0]      i_fwd_data_ok,
    output logic [XLEN-1:0]         o_value,
    output logic                    o_not_ready
);

    logic                 w_addr_nonzero;
    logic [NUM_FWD-1:0]   w_match;
    logic [XLEN-1:0]      w_value;
    logic                 w_not_ready;

    assign w_addr_nonzero = (i_addr != RA_W'(REG_ZERO));

    // Per-source match. Gating on a non-zero index keeps x0 reads pinned to
    // the register file even if a stage claims to write x0.
    generate
        for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_match
            assign w_match[gi] = i_fwd_valid[gi]
                              && (i_fwd_rd[gi*RA_W +: RA_W] == i_addr)
                              && w_addr_nonzero;
        end
    endgenerate

    // Walk from oldest to youngest so the lowest matching index is the last
    // assignment and therefore wins.
    always_comb begin
        w_value     = i_rf_data;
        w_not_ready = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_value     = i_fwd_data[i*XLEN +: XLEN];
                w_not_ready = !i_fwd_data_ok[i];
            end
        end
    end

    assign o_value     = w_value;
    assign o_not_ready = w_not_ready;

endmodule : alu_operand_stage_fwd_resolve

// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//
// Purpose : Selects the two ALU operands (register file / PC / immediate /
//           constants), resolves RAW hazards through NUM_FWD forwarding
//           sources and registers the result into the ID/EX boundary behind
//           a valid/ready handshake. A forwarding hit on a result that is not
//           yet available (load-use) stalls the stage and is counted in a
//           saturating stall counter.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   flush               - kill held operands, block input this cycle
//   in_valid / in_ready - upstream handshake (decode / register read)
//   d1_sel, d2_sel      - operand source selects (see package encodings)
//   rs1_addr, rs2_addr  - source register indices
//   rs1_data, rs2_data  - register file reads
//   immediate, pc       - decoded immediate and instruction PC
//   fwd_valid, fwd_rd, fwd_data, fwd_data_ok - forwarding sources, 0 youngest
//   out_valid / out_ready - downstream handshake (ALU / EX)
//   alu_data_1/2        - registered operands
//   store_data          - registered forwarded rs2, independent of d2_sel
//   stall_count         - saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned RA_W    = 5,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              d1_sel,
    input  logic [1:0]              d2_sel,
    input  logic [RA_W-1:0]         rs1_addr,
    input  logic [RA_W-1:0]         rs2_addr,
    input  logic [XLEN-1:0]         rs1_data,
    input  logic [XLEN-1:0]         rs2_data,
    input  logic [XLEN-1:0]         immediate,
    input  logic [XLEN-1:0]         pc,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD*RA_W-1:0] fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]      fwd_data_ok,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         alu_data_1,
    output logic [XLEN-1:0]         alu_data_2,
    output logic [XLEN-1:0]         store_data,
    output logic [CNT_W-1:0]        stall_count
);

    // -------------------------------------------------------------------------
    // Forward resolution for both sources
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] w_rs1_value;
    logic [XLEN-1:0] w_rs2_value;
    logic            w_rs1_not_ready;
    logic            w_rs2_not_ready;

    alu_operand_stage_fwd_resolve #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD),
        .RA_W    (RA_W)
    ) u_fwd_resolve_rs1 (
        .i_addr        (rs1_addr),
        .i_rf_data     (rs1_data),
        .i_fwd_valid   (fwd_valid),
        .i_fwd_rd      (fwd_rd),
        .i_fwd_data    (fwd_data),
        .i_fwd_data_ok (fwd_data_ok),
        .o_value       (w_rs1_value),
        .o_not_ready   (w_rs1_not_ready)
    );

    alu_operand_stage_fwd_resolve #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD),
        .RA_W    (RA_W)
    ) u_fwd_resolve_rs2 (
        .i_addr        (rs2_addr),
        .i_rf_data     (rs2_data),
        .i_fwd_valid   (fwd_valid),
        .i_fwd_rd      (fwd_rd),
        .i_fwd_data    (fwd_data),
        .i_fwd_data_ok (fwd_data_ok),
        .o_value       (w_rs2_value),
        .o_not_ready   (w_rs2_not_ready)
    );

    // -------------------------------------------------------------------------
    // Operand muxes
    // -------------------------------------------------------------------------
    op1_sel_e        w_d1_sel;
    op2_sel_e        w_d2_sel;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;

    assign w_d1_sel = op1_sel_e'(d1_sel);
    assign w_d2_sel = op2_sel_e'(d2_sel);

    always_comb begin
        w_op1 = '0;
        unique case (w_d1_sel)
            OP1_RS1:  w_op1 = w_rs1_value;
            OP1_PC:   w_op1 = pc;
            OP1_ZERO: w_op1 = '0;
            OP1_RSVD: w_op1 = '0;
            default:  w_op1 = '0;
        endcase
    end

    always_comb begin
        w_op2 = '0;
        unique case (w_d2_sel)
            OP2_RS2:  w_op2 = w_rs2_value;
            OP2_IMM:  w_op2 = immediate;
            OP2_FOUR: w_op2 = XLEN'(CONST_FOUR);
            OP2_RSVD: w_op2 = '0;
            default:  w_op2 = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Hazard detection and handshake
    // -------------------------------------------------------------------------
    logic w_rs1_check;
    logic w_rs2_check;
    logic w_hazard;
    logic w_in_ready;
    logic w_load;
    logic r_out_valid;

    // rs1 only matters when it actually feeds operand 1.
    assign w_rs1_check = (w_d1_sel == OP1_RS1);

    // rs2 also feeds store_data, so any non-zero rs2 index is checked even
    // when operand 2 comes from elsewhere; the reserved code opts out.
    assign w_rs2_check = (w_d2_sel == OP2_RS2)
                      || ((rs2_addr != RA_W'(REG_ZERO)) && (w_d2_sel != OP2_RSVD));

    assign w_hazard = in_valid
                   && ((w_rs1_check && w_rs1_not_ready)
                    || (w_rs2_check && w_rs2_not_ready));

    // The output register can take new data if it is empty or being drained
    // in this same cycle, which gives one transfer per clock.
    assign w_in_ready = !w_hazard && !flush && (!r_out_valid || out_ready);
    assign w_load     = in_valid && w_in_ready;

    // -------------------------------------------------------------------------
    // ID/EX boundary registers
    // -------------------------------------------------------------------------
    logic [XLEN-1:0]  r_alu_data_1;
    logic [XLEN-1:0]  r_alu_data_2;
    logic [XLEN-1:0]  r_store_data;
    logic [CNT_W-1:0] r_stall_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_alu_data_1 <= '0;
            r_alu_data_2 <= '0;
            r_store_data <= '0;
        end else if (flush) begin
            // Data registers are left as-is; out_valid low makes them dead.
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid  <= 1'b1;
            r_alu_data_1 <= w_op1;
            r_alu_data_2 <= w_op2;
            r_store_data <= w_rs2_value;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Counts every hazard cycle regardless of flush or backpressure; it
    // sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_hazard && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign alu_data_1  = r_alu_data_1;
    assign alu_data_2  = r_alu_data_2;
    assign store_data  = r_store_data;
    assign stall_count = r_stall_count;

endmodule : alu_operand_stage

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
//
// Directed bench for alu_operand_stage with a scoreboard: the stimulus side
// pushes the hand-computed operand triple for each instruction it expects the
// stage to accept; a monitor pops and compares whenever an output transfer
// (out_valid && out_ready) is about to happen.
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NUM_FWD = 2;
    localparam int unsigned RA_W    = 5;
    localparam int unsigned CNT_W   = 4;

    logic                    clk;
    logic                    rst_n;
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [1:0]              d1_sel;
    logic [1:0]              d2_sel;
    logic [RA_W-1:0]         rs1_addr;
    logic [RA_W-1:0]         rs2_addr;
    logic [XLEN-1:0]         rs1_data;
    logic [XLEN-1:0]         rs2_data;
    logic [XLEN-1:0]         immediate;
    logic [XLEN-1:0]         pc;
    logic [NUM_FWD-1:0]      fwd_valid;
    logic [NUM_FWD*RA_W-1:0] fwd_rd;
    logic [NUM_FWD*XLEN-1:0] fwd_data;
    logic [NUM_FWD-1:0]      fwd_data_ok;
    logic                    out_valid;
    logic                    out_ready;
    logic [XLEN-1:0]         alu_data_1;
    logic [XLEN-1:0]         alu_data_2;
    logic [XLEN-1:0]         store_data;
    logic [CNT_W-1:0]        stall_count;

    alu_operand_stage #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD),
        .RA_W    (RA_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .d1_sel      (d1_sel),
        .d2_sel      (d2_sel),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .immediate   (immediate),
        .pc          (pc),
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .fwd_data_ok (fwd_data_ok),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_data_1  (alu_data_1),
        .alu_data_2  (alu_data_2),
        .store_data  (store_data),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] d1;
        logic [XLEN-1:0] d2;
        logic [XLEN-1:0] st;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: a transfer happens at the next rising edge when both are high.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_output: got out_valid=1 alu1=0x%0h, expected no pending transaction", alu_data_1);
            end else begin
                e = sb_q.pop_front();
                check("out_alu_data_1", alu_data_1, e.d1);
                check("out_alu_data_2", alu_data_2, e.d2);
                check("out_store_data", store_data, e.st);
                $display("[TB] xfer alu1=0x%0h alu2=0x%0h store=0x%0h", alu_data_1, alu_data_2, store_data);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid    = 1'b0;
        flush       = 1'b0;
        fwd_valid   = '0;
        fwd_rd      = '0;
        fwd_data    = '0;
        fwd_data_ok = '1;
    endtask

    task automatic instr(input logic [1:0] s1, input logic [1:0] s2,
                         input logic [RA_W-1:0] a1, input logic [RA_W-1:0] a2,
                         input logic [XLEN-1:0] v1, input logic [XLEN-1:0] v2,
                         input logic [XLEN-1:0] im, input logic [XLEN-1:0] p);
        in_valid  = 1'b1;
        d1_sel    = s1;
        d2_sel    = s2;
        rs1_addr  = a1;
        rs2_addr  = a2;
        rs1_data  = v1;
        rs2_data  = v2;
        immediate = im;
        pc        = p;
    endtask

    task automatic push(input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                        input logic [XLEN-1:0] st);
        exp_t e;
        e.d1 = d1;
        e.d2 = d2;
        e.st = st;
        sb_q.push_back(e);
    endtask

    task automatic discard();
        if (sb_q.size() > 0) void'(sb_q.pop_front());
    endtask

    initial begin : stimulus
        // ---------------- reset ----------------
        rst_n     = 1'b0;
        out_ready = 1'b0;
        d1_sel    = 2'b00;
        d2_sel    = 2'b00;
        rs1_addr  = '0;
        rs2_addr  = '0;
        rs1_data  = '0;
        rs2_data  = '0;
        immediate = '0;
        pc        = '0;
        idle();
        #2;
        check("rst_out_valid",   out_valid,   0);
        check("rst_alu_data_1",  alu_data_1,  0);
        check("rst_alu_data_2",  alu_data_2,  0);
        check("rst_store_data",  store_data,  0);
        check("rst_stall_count", stall_count, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- basic selects, back-to-back ----------------
        out_ready = 1'b1;
        instr(2'b00, 2'b01, 5'd1, 5'd0, 32'h10, 32'h99, 32'h20, 32'h100);
        #1 check("b2b_in_ready_0", in_ready, 1);
        push(32'h10, 32'h20, 32'h99);
        tick();
        instr(2'b01, 2'b10, 5'd1, 5'd3, 32'h10, 32'h33, 32'h20, 32'h100);
        #1 check("b2b_in_ready_1", in_ready, 1);
        push(32'h100, 32'h4, 32'h33);
        tick();
        instr(2'b10, 2'b11, 5'd1, 5'd0, 32'h10, 32'h44, 32'h20, 32'h100);
        #1 check("b2b_in_ready_2", in_ready, 1);
        push(32'h0, 32'h0, 32'h44);
        tick();
        idle();
        tick();
        check("drain_out_valid", out_valid, 0);

        // ---------------- forwarding priority / x0 ----------------
        fwd_valid   = 2'b11;
        fwd_rd      = {5'd5, 5'd5};
        fwd_data    = {32'hBBBB, 32'hAAAA};
        fwd_data_ok = 2'b11;
        instr(2'b00, 2'b00, 5'd5, 5'd6, 32'h55, 32'h66, 32'h0, 32'h0);
        #1 check("fwd_in_ready", in_ready, 1);
        push(32'hAAAA, 32'h66, 32'h66);
        tick();
        fwd_rd = {5'd0, 5'd0};
        instr(2'b00, 2'b00, 5'd0, 5'd6, 32'h1111, 32'h66, 32'h0, 32'h0);
        push(32'h1111, 32'h66, 32'h66);
        tick();
        fwd_rd    = {5'd5, 5'd5};
        fwd_valid = 2'b10;
        instr(2'b00, 2'b00, 5'd5, 5'd6, 32'h55, 32'h66, 32'h0, 32'h0);
        push(32'hBBBB, 32'h66, 32'h66);
        tick();
        idle();
        tick();

        // ---------------- load-use stall ----------------
        fwd_valid   = 2'b01;
        fwd_rd      = {5'd0, 5'd7};
        fwd_data    = {32'h0, 32'h1234};
        fwd_data_ok = 2'b00;
        instr(2'b00, 2'b00, 5'd0, 5'd7, 32'h7, 32'h70, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1 check("loaduse_in_ready_low", in_ready, 0);
            tick();
        end
        check("loaduse_stall_count", stall_count, 3);
        check("loaduse_no_output", out_valid, 0);
        fwd_data_ok = 2'b01;
        #1 check("loaduse_in_ready_high", in_ready, 1);
        push(32'h7, 32'h1234, 32'h1234);
        tick();
        idle();
        tick();

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        instr(2'b00, 2'b01, 5'd2, 5'd0, 32'hD1, 32'hD3, 32'hD2, 32'h0);
        #1 check("bp_in_ready_empty", in_ready, 1);
        push(32'hD1, 32'hD2, 32'hD3);
        tick();
        instr(2'b00, 2'b01, 5'd2, 5'd0, 32'hE1, 32'hE3, 32'hE2, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_in_ready_low", in_ready,   0);
            check("bp_out_valid",    out_valid,  1);
            check("bp_hold_alu1",    alu_data_1, 32'hD1);
            check("bp_hold_alu2",    alu_data_2, 32'hD2);
            check("bp_hold_store",   store_data, 32'hD3);
            tick();
        end
        out_ready = 1'b1;
        #1 check("bp_release_in_ready", in_ready, 1);
        push(32'hE1, 32'hE2, 32'hE3);
        tick();
        idle();
        tick();

        // ---------------- flush ----------------
        out_ready = 1'b0;
        instr(2'b00, 2'b01, 5'd2, 5'd0, 32'hF1, 32'hF3, 32'hF2, 32'h0);
        push(32'hF1, 32'hF2, 32'hF3);
        tick();
        flush = 1'b1;
        instr(2'b00, 2'b01, 5'd2, 5'd0, 32'hA1, 32'hA3, 32'hA2, 32'h0);
        #1 check("flush_in_ready", in_ready, 0);
        tick();
        check("flush_out_valid", out_valid, 0);
        discard();
        flush       = 1'b0;
        out_ready   = 1'b1;
        fwd_valid   = 2'b01;
        fwd_rd      = {5'd0, 5'd9};
        fwd_data    = {32'h0, 32'hF00D};
        fwd_data_ok = 2'b11;
        instr(2'b01, 2'b10, 5'd3, 5'd9, 32'h31, 32'h999, 32'h0, 32'h200);
        #1 check("post_flush_in_ready", in_ready, 1);
        push(32'h200, 32'h4, 32'hF00D);
        tick();
        idle();
        tick();

        // ---------------- counter saturation + async reset ----------------
        out_ready = 1'b0;
        instr(2'b00, 2'b01, 5'd2, 5'd0, 32'h11, 32'h13, 32'h12, 32'h0);
        push(32'h11, 32'h12, 32'h13);
        tick();
        fwd_valid   = 2'b01;
        fwd_rd      = {5'd0, 5'd4};
        fwd_data    = {32'h0, 32'h4444};
        fwd_data_ok = 2'b00;
        instr(2'b00, 2'b01, 5'd4, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 20; i++) tick();
        check("sat_stall_count", stall_count, 15);
        check("sat_out_valid_held", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_stall_count", stall_count, 0);
        check("async_rst_out_valid",   out_valid,   0);
        check("async_rst_alu1",        alu_data_1,  0);
        check("async_rst_store",       store_data,  0);
        discard();
        idle();
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- resume after reset ----------------
        out_ready = 1'b1;
        instr(2'b00, 2'b01, 5'd1, 5'd0, 32'h21, 32'h23, 32'h22, 32'h0);
        #1 check("resume_in_ready", in_ready, 1);
        push(32'h21, 32'h22, 32'h23);
        tick();
        idle();
        tick();
        tick();
        check("resume_out_valid", out_valid, 0);
        check("resume_stall_count", stall_count, 0);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_alu_operand_stage
